// File: rtl/key_motion_pkg.sv
// Shared types for the key-to-motion scheduler: command and FSM enums,
// HID keycode constants and the keycode decoder.
package key_motion_pkg;

    typedef enum logic [2:0] {
        CMD_STOP,
        CMD_UP,
        CMD_DOWN,
        CMD_LEFT,
        CMD_RIGHT
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    localparam logic [7:0] KC_NONE = 8'h00;
    localparam logic [7:0] KC_W    = 8'h1A;
    localparam logic [7:0] KC_A    = 8'h04;
    localparam logic [7:0] KC_S    = 8'h16;
    localparam logic [7:0] KC_D    = 8'h07;

    typedef struct packed {
        logic valid;
        cmd_t cmd;
    } dec_t;

    function automatic dec_t decode_key(input logic [7:0] kc);
        dec_t d;
        d.valid = 1'b1;
        d.cmd   = CMD_STOP;
        case (kc)
            KC_W:    d.cmd = CMD_UP;
            KC_S:    d.cmd = CMD_DOWN;
            KC_A:    d.cmd = CMD_LEFT;
            KC_D:    d.cmd = CMD_RIGHT;
            KC_NONE: d.cmd = CMD_STOP;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_motion_scheduler_cmd_fifo.sv
// Command FIFO: power-of-2 depth, pointers wrap naturally; a push into a full
// FIFO is dropped (drop_o pulses) unless a pop frees a slot in the same cycle.
module cmd_fifo
    import key_motion_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  cmd_t                     data_i,
    output cmd_t                     data_o,
    output logic                     empty_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     cnt_q;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/key_motion_scheduler.sv
// Decodes keycode changes into motion commands and releases one per vsync frame.
// Optional auto-repeat of a held key is built when KEY_REPEAT_EN is defined.
module key_motion_scheduler
    import key_motion_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int          STEP          = 1,
    parameter int unsigned REPEAT_FRAMES = 30
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [7:0]                      keycode,
    input  logic                            vs,
    output logic signed [9:0]               X_Motion,
    output logic signed [9:0]               Y_Motion,
    output logic                            cmd_strobe,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam logic signed [9:0] STEP_S = 10'(STEP);

    state_t             state_q, state_d;
    logic [7:0]         prev_kc_q;
    logic               vs_meta_q, vs_sync_q, vs_prev_q;
    logic signed [9:0]  x_q, y_q, step_x, step_y;
    logic               strobe_q, ovf_q;
    logic               frame_tick, chg_push, push, pop, fifo_empty, fifo_drop;
    cmd_t               head;
    dec_t               dec;

    assign dec        = decode_key(keycode);
    assign chg_push   = (keycode != prev_kc_q) && dec.valid;
    assign frame_tick = vs_prev_q & ~vs_sync_q;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rep_cnt_q;
    logic          key_stable, rep_push;

    assign key_stable = (keycode == prev_kc_q) && (keycode != KC_NONE) && dec.valid;
    // Repeat push is issued during ISSUE so it queues behind this frame's pop.
    assign rep_push   = key_stable && (state_q == ST_ISSUE) && (rep_cnt_q == RW'(REPEAT_FRAMES));
    assign push       = chg_push | rep_push;

    always_ff @(posedge Clk) begin
        if (Reset || !key_stable || rep_push) begin
            rep_cnt_q <= '0;
        end else if (frame_tick) begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_repeat_frames;
    assign unused_repeat_frames = 32'(REPEAT_FRAMES);
    assign push = chg_push;
`endif

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (dec.cmd),
        .data_o  (head),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE:  if (frame_tick) state_d = ST_ISSUE;
            ST_ISSUE: begin
                pop     = !fifo_empty;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_x = '0;
        step_y = '0;
        case (head)
            CMD_UP:    step_y = -STEP_S;
            CMD_DOWN:  step_y = STEP_S;
            CMD_LEFT:  step_x = -STEP_S;
            CMD_RIGHT: step_x = STEP_S;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            prev_kc_q <= KC_NONE;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_prev_q <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            strobe_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_kc_q <= keycode;
            vs_meta_q <= vs;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            strobe_q  <= pop;
            ovf_q     <= ovf_q | fifo_drop;
            if (pop) begin
                x_q <= step_x;
                y_q <= step_y;
            end
        end
    end

    assign X_Motion   = x_q;
    assign Y_Motion   = y_q;
    assign cmd_strobe = strobe_q;
    assign overflow   = ovf_q;

endmodule
